pico_io_hub: RTL and testbench

- Parametrised port-mapped I/O hub between a KCPSM3-class processor (port_id/strobe bus) and board I/O.
- Provides N_OUT write-only output registers.
- Provides N_BTN button channels, each with a synchroniser, debounce, sticky press flag, wrapping press counter and maskable interrupt.
- Read-back covers switches, debounced levels, flags and counters; successor to the fixed 4-display/2-button interface.

---
 rtl/pico_io_pkg.sv | 21 ++
 rtl/btn_debounce_ch.sv | 68 ++++++
 rtl/pico_io_hub.sv | 134 +++++++++++++
 tb/tb_pico_io_hub.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pico_io_pkg.sv
// rtl/pico_io_pkg.sv - shared port address map for the pico I/O hub
//
// Purpose: single place for every processor port address the hub decodes,
//          so the top level and anything that talks to it agree on the map.
// Contents: write addresses (OUT_BASE, MASK_WR, CNT_CLR) and read addresses
//           (FLAG_RD, SW_RD, LVL_RD, MASK_RD, CNT_RD_BASE).
package pico_io_pkg;

   // Write map
   localparam logic [7:0] OUT_BASE    = 8'h00;
   localparam logic [7:0] MASK_WR     = 8'h80;
   localparam logic [7:0] CNT_CLR     = 8'h81;

   // Read map
   localparam logic [7:0] FLAG_RD     = 8'h00;
   localparam logic [7:0] SW_RD       = 8'h01;
   localparam logic [7:0] LVL_RD      = 8'h02;
   localparam logic [7:0] MASK_RD     = 8'h03;
   localparam logic [7:0] CNT_RD_BASE = 8'h40;

endpackage

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - one button channel: synchroniser, debounce, press tick
//
// Purpose: brings one raw asynchronous pushbutton into the clock domain and
//          only moves the debounced level after DB_CYCLES consecutive cycles
//          in which the synchronised input disagrees with it.
// Ports:
//   clk_i    system clock
//   rst_ni   asynchronous active-low reset
//   btn_i    raw button, active-high
//   level_o  debounced level
//   press_o  one-cycle tick, high in the cycle before level_o rises
module btn_debounce_ch #(
   parameter int DB_CYCLES = 1000000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   output logic level_o,
   output logic press_o
);

   localparam int            CW       = $clog2(DB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          level_q;
   logic          level_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          toggle;

   // Counter only runs while the synchronised input differs from the level;
   // any agreeing cycle restarts the count, which is what rejects glitches.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      toggle  = 1'b0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            toggle  = 1'b1;
            level_d = ~level_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level_o = level_q;
   // Tick is aligned with the edge that raises the level, so flags and
   // counters in the parent update on that same edge. Releases never tick.
   assign press_o = toggle & ~level_q;

endmodule

// File: rtl/pico_io_hub.sv
// rtl/pico_io_hub.sv - port-mapped I/O hub for a KCPSM3-class processor
//
// Purpose: N_OUT write-only output registers plus N_BTN debounced button
//          channels with sticky press flags, wrapping press counters and a
//          maskable level interrupt, all behind the port_id/strobe bus.
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   port_id, write_strobe,
//   read_strobe, out_port         processor bus inputs
//   in_port                       read data, combinational from port_id
//   sw                            raw static switches (zero-extended on read)
//   btn                           raw pushbuttons, active-high
//   out_regs                      output registers, reg i at [8i+7:8i]
//   btn_level                     debounced button levels
//   irq                           registered |(flags & mask)
module pico_io_hub
   import pico_io_pkg::*;
#(
   parameter int N_OUT     = 4,
   parameter int N_BTN     = 2,
   parameter int DB_CYCLES = 1000000,
   parameter int SW_W      = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [7:0]           port_id,
   input  logic                 write_strobe,
   input  logic                 read_strobe,
   input  logic [7:0]           out_port,
   output logic [7:0]           in_port,
   input  logic [SW_W-1:0]      sw,
   input  logic [N_BTN-1:0]     btn,
   output logic [8*N_OUT-1:0]   out_regs,
   output logic [N_BTN-1:0]     btn_level,
   output logic                 irq
);

   logic [N_BTN-1:0] press;
   logic [N_BTN-1:0] flags_q, flags_d;
   logic [N_BTN-1:0] mask_q,  mask_d;
   logic [7:0]       cnt_q [N_BTN];
   logic [7:0]       cnt_d [N_BTN];
   logic [7:0]       out_q [N_OUT];
   logic [7:0]       out_d [N_OUT];
   logic             irq_q, irq_d;

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      btn_debounce_ch #(
         .DB_CYCLES (DB_CYCLES)
      ) u_db (
         .clk_i   (clk),
         .rst_ni  (reset_n),
         .btn_i   (btn[i]),
         .level_o (btn_level[i]),
         .press_o (press[i])
      );
   end

   for (genvar i = 0; i < N_OUT; i++) begin : g_out
      assign out_regs[8*i +: 8] = out_q[i];
   end

   always_comb begin
      for (int i = 0; i < N_OUT; i++) begin
         out_d[i] = out_q[i];
         if (write_strobe && (port_id == OUT_BASE + 8'(i))) begin
            out_d[i] = out_port;
         end
      end

      mask_d = mask_q;
      if (write_strobe && (port_id == MASK_WR)) begin
         mask_d = out_port[N_BTN-1:0];
      end

      // Clear first, then OR in this cycle's ticks: a press that lands on
      // the clearing read is kept, never lost.
      flags_d = flags_q;
      if (read_strobe && (port_id == FLAG_RD)) begin
         flags_d = '0;
      end
      flags_d = flags_d | press;

      // Same ordering for counters: clear-and-tick leaves the count at 1.
      for (int i = 0; i < N_BTN; i++) begin
         cnt_d[i] = cnt_q[i];
         if (write_strobe && (port_id == CNT_CLR)) begin
            cnt_d[i] = 8'h00;
         end
         if (press[i]) begin
            cnt_d[i] = cnt_d[i] + 8'h01;
         end
      end

      irq_d = |(flags_d & mask_d);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N_OUT; i++) out_q[i] <= 8'h00;
         for (int i = 0; i < N_BTN; i++) cnt_q[i] <= 8'h00;
         flags_q <= '0;
         mask_q  <= '0;
         irq_q   <= 1'b0;
      end else begin
         for (int i = 0; i < N_OUT; i++) out_q[i] <= out_d[i];
         for (int i = 0; i < N_BTN; i++) cnt_q[i] <= cnt_d[i];
         flags_q <= flags_d;
         mask_q  <= mask_d;
         irq_q   <= irq_d;
      end
   end

   assign irq = irq_q;

   // Read mux; narrow fields are placed in the low bits of a zeroed byte.
   always_comb begin
      in_port = 8'h00;
      unique case (port_id)
         FLAG_RD: in_port[N_BTN-1:0] = flags_q;
         SW_RD:   in_port[SW_W-1:0]  = sw;
         LVL_RD:  in_port[N_BTN-1:0] = btn_level;
         MASK_RD: in_port[N_BTN-1:0] = mask_q;
         default: begin
            for (int i = 0; i < N_BTN; i++) begin
               if (port_id == CNT_RD_BASE + 8'(i)) begin
                  in_port = cnt_q[i];
               end
            end
         end
      endcase
   end

endmodule

// File: tb/tb_pico_io_hub.sv
// tb/tb_pico_io_hub.sv - directed self-checking bench for pico_io_hub
module tb_pico_io_hub;

   logic        clk;
   logic        reset_n;
   logic [7:0]  port_id;
   logic        write_strobe;
   logic        read_strobe;
   logic [7:0]  out_port;
   logic [7:0]  in_port;
   logic [7:0]  sw;
   logic [1:0]  btn;
   logic [31:0] out_regs;
   logic [1:0]  btn_level;
   logic        irq;

   int n_chk  = 0;
   int n_pass = 0;

   pico_io_hub #(
      .N_OUT     (4),
      .N_BTN     (2),
      .DB_CYCLES (4),
      .SW_W      (8)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .port_id      (port_id),
      .write_strobe (write_strobe),
      .read_strobe  (read_strobe),
      .out_port     (out_port),
      .in_port      (in_port),
      .sw           (sw),
      .btn          (btn),
      .out_regs     (out_regs),
      .btn_level    (btn_level),
      .irq          (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      port_id      = a;
      out_port     = d;
      write_strobe = 1'b1;
      cycles(1);
      write_strobe = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [7:0] d);
      port_id     = a;
      #1;
      d           = in_port;
      read_strobe = 1'b1;
      cycles(1);
      read_strobe = 1'b0;
   endtask

   task automatic peek(input logic [7:0] a, output logic [7:0] d);
      port_id = a;
      #1;
      d = in_port;
   endtask

   task automatic press(input int b);
      btn[b] = 1'b1;
      cycles(8);
      btn[b] = 1'b0;
      cycles(8);
   endtask

   // Edges counted from the raise of btn[b] until btn_level[b] goes high,
   // capped at 10; returns 0 if it never rose.
   task automatic rise_latency(input int b, output int lat);
      lat = 0;
      btn[b] = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         cycles(1);
         if (lat == 0 && btn_level[b]) lat = k;
      end
   endtask

   logic [7:0] v;
   int         lat;

   initial begin
      reset_n      = 1'b0;
      port_id      = 8'h00;
      write_strobe = 1'b0;
      read_strobe  = 1'b0;
      out_port     = 8'h00;
      sw           = 8'h5A;
      btn          = 2'b00;
      cycles(2);
      chk("rst_out_regs", out_regs, 32'h0);
      chk("rst_irq", irq, 1'b0);
      chk("rst_level", btn_level, 2'b00);
      reset_n = 1'b1;
      cycles(1);
      peek(8'h00, v); chk("rst_flags", v, 8'h00);
      peek(8'h01, v); chk("sw_read", v, 8'h5A);
      peek(8'h03, v); chk("rst_mask", v, 8'h00);

      // Output decode, out-of-range write ignored
      wr(8'h02, 8'hA5);
      wr(8'h05, 8'h3C);
      chk("out_decode", out_regs, 32'h00A5_0000);
      peek(8'h10, v); chk("unmapped_rd", v, 8'h00);
      peek(8'h42, v); chk("cnt_rd_oob", v, 8'h00);

      // 3-cycle glitch is rejected
      btn = 2'b01;
      cycles(3);
      btn = 2'b00;
      cycles(10);
      chk("glitch_level", btn_level, 2'b00);
      peek(8'h00, v); chk("glitch_flags", v, 8'h00);

      // Clean press: level rises exactly DB_CYCLES+2 = 6 edges after the raise
      rise_latency(0, lat);
      chk("db_latency", lat, 6);
      btn = 2'b00;
      cycles(10);
      peek(8'h00, v); chk("press_flag", v, 8'h01);
      peek(8'h40, v); chk("press_cnt0", v, 8'h01);
      peek(8'h02, v); chk("release_level", v, 8'h00);
      rd(8'h00, v);   chk("flag_rd_val", v, 8'h01);
      peek(8'h00, v); chk("flag_cleared", v, 8'h00);

      // Counter wrap on btn[1]
      repeat (255) press(1);
      peek(8'h41, v); chk("cnt1_ff", v, 8'hFF);
      press(1);
      peek(8'h41, v); chk("cnt1_wrap", v, 8'h00);
      peek(8'h00, v); chk("wrap_flags", v, 8'h02);
      wr(8'h81, 8'h00);
      peek(8'h40, v); chk("cnt_clr0", v, 8'h00);
      peek(8'h41, v); chk("cnt_clr1", v, 8'h00);

      // Flag clear racing a btn[1] tick: set wins
      rd(8'h00, v);
      press(0);
      btn = 2'b10;
      cycles(5);
      rd(8'h00, v);   chk("race_rd_val", v, 8'h01);
      peek(8'h00, v); chk("race_flags", v, 8'h02);
      chk("race_level", btn_level, 2'b10);
      btn = 2'b00;
      cycles(10);

      // Counter clear racing a btn[1] tick: counter ends at 1
      btn = 2'b10;
      cycles(5);
      wr(8'h81, 8'h00);
      peek(8'h41, v); chk("clr_race_cnt1", v, 8'h01);
      peek(8'h40, v); chk("clr_race_cnt0", v, 8'h00);
      btn = 2'b00;
      cycles(10);

      // Interrupt masking
      rd(8'h00, v);
      wr(8'h80, 8'h02);
      peek(8'h03, v); chk("mask_rd", v, 8'h02);
      press(0);
      chk("irq_masked", irq, 1'b0);
      peek(8'h00, v); chk("irq_flags0", v, 8'h01);
      press(1);
      chk("irq_set", irq, 1'b1);
      peek(8'h00, v); chk("irq_flags1", v, 8'h03);
      rd(8'h00, v);
      chk("irq_clear", irq, 1'b0);

      // Async reset mid-debounce with flags = 0x03
      press(0);
      press(1);
      wr(8'h01, 8'h55);
      chk("pre_rst_irq", irq, 1'b1);
      btn = 2'b01;
      cycles(3);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_out_regs", out_regs, 32'h0);
      chk("arst_irq", irq, 1'b0);
      chk("arst_level", btn_level, 2'b00);
      peek(8'h00, v); chk("arst_flags", v, 8'h00);
      peek(8'h03, v); chk("arst_mask", v, 8'h00);
      btn = 2'b00;
      cycles(1);
      reset_n = 1'b1;
      cycles(12);
      peek(8'h00, v); chk("no_tick_flags", v, 8'h00);
      chk("no_tick_level", btn_level, 2'b00);

      // Held through reset: press appears DB_CYCLES+2 edges after release
      btn = 2'b10;
      cycles(2);
      #2;
      reset_n = 1'b0;
      cycles(2);
      reset_n = 1'b1;
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         cycles(1);
         if (lat == 0 && btn_level[1]) lat = k;
      end
      chk("held_latency", lat, 6);
      peek(8'h00, v); chk("held_flags", v, 8'h02);
      peek(8'h41, v); chk("held_cnt1", v, 8'h01);
      btn = 2'b00;
      cycles(4);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
